// File: rtl/nettlp_rx_decap.sv
// NetTLP receive decapsulator: validates the Eth/IPv4/UDP/NetTLP header of MAC RX frames and forwards the bare TLP.
// Optional NETTLP_SEQ_CHECK_EN adds per-tag sequence checking (seq_err, seq_err_cnt).
module nettlp_rx_decap #(
    parameter int          DATA_WIDTH    = 64,
    parameter int          KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
    parameter int          TAG_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [TAG_WIDTH-1:0]  m_tlp_tag,
    output logic [15:0]           m_tlp_seq,
    output logic [31:0]           m_tlp_tstamp,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt
`ifdef NETTLP_SEQ_CHECK_EN
    ,
    output logic                  seq_err,
    output logic [31:0]           seq_err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    localparam int NUM_TAGS = 1 << TAG_WIDTH;

    state_t                state_q, state_d;
    logic [2:0]            beat_q, beat_d;
    logic                  hdr_ok_q, hdr_ok_d;
    logic [TAG_WIDTH-1:0]  tag_pend_q, tag_pend_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [15:0]           seq_q, seq_d;
    logic [31:0]           tstamp_q, tstamp_d;
    logic [31:0]           pkt_cnt_q, pkt_cnt_d;
    logic [31:0]           drop_cnt_q, drop_cnt_d;

`ifdef NETTLP_SEQ_CHECK_EN
    logic [15:0]           exp_seq_q [NUM_TAGS];
    logic [15:0]           exp_seq_d [NUM_TAGS];
    logic                  seq_err_q, seq_err_d;
    logic [31:0]           seq_err_cnt_q, seq_err_cnt_d;
`endif

    logic                  s_ready_s;
    logic                  s_fire_s;
    logic                  m_fire_s;
    logic [15:0]           port_s;
    logic [16:0]           port_off_s;
    logic                  port_ok_s;
    logic [15:0]           seq_s;
    logic [31:0]           tstamp_s;
    logic                  beat_ok_s;
    logic                  hdr_pass_s;

    // Handshakes and big-endian header field extraction from the current input beat
    always_comb begin
        if (state_q == ST_PAYLOAD) begin
            s_ready_s = !m_valid_q || m_axis_tready;
        end else begin
            s_ready_s = 1'b1;
        end
        s_fire_s   = s_axis_tvalid && s_ready_s;
        m_fire_s   = m_valid_q && m_axis_tready;
        port_s     = {s_axis_tdata[39:32], s_axis_tdata[47:40]};
        // Borrow bit and any bit above the tag field both mean "outside the port window"
        port_off_s = {1'b0, port_s} - {1'b0, UDP_PORT_BASE};
        port_ok_s  = ((port_off_s >> TAG_WIDTH) == 17'd0);
        seq_s      = {s_axis_tdata[23:16], s_axis_tdata[31:24]};
        tstamp_s   = {s_axis_tdata[39:32], s_axis_tdata[47:40],
                      s_axis_tdata[55:48], s_axis_tdata[63:56]};
        case (beat_q)
            3'd1:    beat_ok_s = (s_axis_tdata[39:32] == 8'h08) && (s_axis_tdata[47:40] == 8'h00);
            3'd2:    beat_ok_s = (s_axis_tdata[63:56] == 8'h11);
            3'd4:    beat_ok_s = port_ok_s;
            default: beat_ok_s = 1'b1;
        endcase
        hdr_pass_s = hdr_ok_q && beat_ok_s;
    end

    // Next-state, output register and counter logic
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        hdr_ok_d   = hdr_ok_q;
        tag_pend_d = tag_pend_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        tag_d      = tag_q;
        seq_d      = seq_q;
        tstamp_d   = tstamp_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
`ifdef NETTLP_SEQ_CHECK_EN
        exp_seq_d     = exp_seq_q;
        seq_err_d     = 1'b0;
        seq_err_cnt_d = seq_err_cnt_q;
`endif

        if (m_fire_s) begin
            m_valid_d = 1'b0;
            if (m_last_q) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
        end else begin
            m_valid_d = m_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_fire_s) begin
                    if (s_axis_tlast) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else begin
                        state_d  = ST_HDR;
                        beat_d   = 3'd1;
                        hdr_ok_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (s_fire_s) begin
                    hdr_ok_d = hdr_pass_s;
                    if (beat_q == 3'd4) begin
                        tag_pend_d = port_off_s[TAG_WIDTH-1:0];
                    end else begin
                        tag_pend_d = tag_pend_q;
                    end
                    if (s_axis_tlast) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        state_d    = ST_IDLE;
                    end else if (beat_q == 3'd5) begin
                        if (hdr_pass_s) begin
                            state_d  = ST_PAYLOAD;
                            tag_d    = tag_pend_q;
                            seq_d    = seq_s;
                            tstamp_d = tstamp_s;
`ifdef NETTLP_SEQ_CHECK_EN
                            if (seq_s != exp_seq_q[tag_pend_q]) begin
                                seq_err_d     = 1'b1;
                                seq_err_cnt_d = seq_err_cnt_q + 32'd1;
                            end else begin
                                seq_err_d     = 1'b0;
                            end
                            exp_seq_d[tag_pend_q] = seq_s + 16'd1;
`endif
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (s_fire_s) begin
                    m_data_d  = s_axis_tdata;
                    m_keep_d  = s_axis_tkeep;
                    m_last_d  = s_axis_tlast;
                    m_valid_d = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_DROP: begin
                if (s_fire_s && s_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= 3'd0;
            hdr_ok_q   <= 1'b0;
            tag_pend_q <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            tag_q      <= '0;
            seq_q      <= 16'd0;
            tstamp_q   <= 32'd0;
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
`ifdef NETTLP_SEQ_CHECK_EN
            for (int i = 0; i < NUM_TAGS; i++) begin
                exp_seq_q[i] <= 16'd0;
            end
            seq_err_q     <= 1'b0;
            seq_err_cnt_q <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            hdr_ok_q   <= hdr_ok_d;
            tag_pend_q <= tag_pend_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            tag_q      <= tag_d;
            seq_q      <= seq_d;
            tstamp_q   <= tstamp_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef NETTLP_SEQ_CHECK_EN
            exp_seq_q     <= exp_seq_d;
            seq_err_q     <= seq_err_d;
            seq_err_cnt_q <= seq_err_cnt_d;
`endif
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_tlp_tag     = tag_q;
    assign m_tlp_seq     = seq_q;
    assign m_tlp_tstamp  = tstamp_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
`ifdef NETTLP_SEQ_CHECK_EN
    assign seq_err       = seq_err_q;
    assign seq_err_cnt   = seq_err_cnt_q;
`endif

endmodule

// File: tb/tb_nettlp_rx_decap.sv
// Self-checking bench for nettlp_rx_decap: directed frame table, reset abort, stall and random traffic vs. a frame-level model.
module tb_nettlp_rx_decap;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [3:0]  m_tlp_tag;
    logic [15:0] m_tlp_seq;
    logic [31:0] m_tlp_tstamp;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
`ifdef NETTLP_SEQ_CHECK_EN
    logic        seq_err;
    logic [31:0] seq_err_cnt;
    int          seq_pulses = 0;
`endif

    always #5 clk = ~clk;

    nettlp_rx_decap dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_tlp_tag(m_tlp_tag), .m_tlp_seq(m_tlp_seq), .m_tlp_tstamp(m_tlp_tstamp),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`ifdef NETTLP_SEQ_CHECK_EN
        , .seq_err(seq_err), .seq_err_cnt(seq_err_cnt)
`endif
    );

    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
    typedef struct { logic [3:0] tag; logic [15:0] seq; logic [31:0] ts; } side_t;
    typedef struct {
        logic [15:0] etype; logic [7:0] proto; logic [15:0] port; logic [15:0] seq;
        logic [31:0] ts; int npay; logic [7:0] lkeep; int trunc; bit acc; int mode;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rdy_mode = 0;
    beat_t       exp_q[$];
    int          acc_q[$];
    side_t       side_q[$];
    logic [31:0] exp_pkt  = 32'd0;
    logic [31:0] exp_drop = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit model_accept(input logic [15:0] etype, input logic [7:0] proto,
                                        input logic [15:0] port, input int trunc);
        return (trunc == 0) && (etype == 16'h0800) && (proto == 8'h11) &&
               (port >= 16'h3000) && (port <= 16'h300F);
    endfunction

    // Downstream ready pattern: always, toggling, or random with at most two idle cycles in a row
    initial begin
        int zrun = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = !m_axis_tready;
                default: begin
                    if (zrun >= 2) m_axis_tready = 1'b1;
                    else m_axis_tready = 1'($urandom_range(0, 1));
                    zrun = m_axis_tready ? 0 : zrun + 1;
                end
            endcase
        end
    end

    // Output monitor: scoreboard order, stall stability, latency and sideband on first beat
    initial begin
        bit          stall_v = 1'b0;
        bit          first_beat = 1'b1;
        logic [72:0] stall_beat = '0;
        beat_t       e;
        int          a;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_v = 1'b0;
                first_beat = 1'b1;
            end else begin
                if (stall_v) begin
                    check("hold_valid", m_axis_tvalid, 1'b1);
                    check("hold_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, stall_beat);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_axis_tdata, e.d);
                        check("out_keep", m_axis_tkeep, e.k);
                        check("out_last", m_axis_tlast, e.l);
                        a = (acc_q.size() > 0) ? acc_q.pop_front() : -1;
                        if (rdy_mode == 0) check("latency", cyc, a);
                        if (first_beat && side_q.size() > 0) begin
                            check("tag", m_tlp_tag, side_q[0].tag);
                            check("seq", m_tlp_seq, side_q[0].seq);
                            check("tstamp", m_tlp_tstamp, side_q[0].ts);
                        end
                        if (e.l) begin
                            if (side_q.size() > 0) void'(side_q.pop_front());
                            first_beat = 1'b1;
                        end else begin
                            first_beat = 1'b0;
                        end
                    end
                end
                stall_v = m_axis_tvalid && !m_axis_tready;
                stall_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            end
        end
    end

`ifdef NETTLP_SEQ_CHECK_EN
    initial forever begin
        @(negedge clk);
        if (!rst && seq_err) seq_pulses++;
    end
`endif

    // Drives one frame; rst_at > 0 pulses reset in place of that beat and abandons the frame
    task automatic send_frame(input logic [15:0] etype, input logic [7:0] proto,
                              input logic [15:0] port, input logic [15:0] seq,
                              input logic [31:0] ts, input int npay, input logic [7:0] lkeep,
                              input int trunc, input int rst_at, input bit acc);
        logic [7:0]  hb [48];
        logic [63:0] d;
        logic [7:0]  k;
        logic [15:0] off;
        side_t       sd;
        int          total, n;
        for (int i = 0; i < 48; i++) hb[i] = 8'($urandom);
        hb[12] = etype[15:8]; hb[13] = etype[7:0];
        hb[23] = proto;
        hb[36] = port[15:8];  hb[37] = port[7:0];
        hb[42] = seq[15:8];   hb[43] = seq[7:0];
        hb[44] = ts[31:24]; hb[45] = ts[23:16]; hb[46] = ts[15:8]; hb[47] = ts[7:0];
        total = (trunc > 0) ? trunc : 6 + npay;
        if (acc) begin
            off = port - 16'h3000;
            sd.tag = off[3:0]; sd.seq = seq; sd.ts = ts;
            side_q.push_back(sd);
        end
        for (int b = 0; b < total; b++) begin
            if (rst_at != 0 && b == rst_at) begin
                rst = 1'b1;
                s_axis_tvalid = 1'b0;
                s_axis_tlast = 1'b0;
                exp_q.delete(); acc_q.delete(); side_q.delete();
                exp_pkt = 32'd0; exp_drop = 32'd0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            for (int j = 0; j < 8; j++) d[8*j +: 8] = (b < 6) ? hb[8*b + j] : 8'($urandom);
            k = (b == total - 1 && b >= 6) ? lkeep : 8'hFF;
            if (acc && b >= 6) exp_q.push_back('{d, k, (b == total - 1)});
            s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = (b == total - 1);
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            if (!acc || b < 6) check("in_ready", s_axis_tready, 1'b1);
            n = 0;
            while (!s_axis_tready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) check("in_timeout", 1'b0, 1'b1);
            if (acc && b >= 6) acc_q.push_back(cyc + 1);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        if (acc) exp_pkt = exp_pkt + 32'd1;
        else exp_drop = exp_drop + 32'd1;
    endtask

    task automatic drain_and_check(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin @(posedge clk); n++; end
        if (n >= 500) check({tag, "_drain"}, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    endtask

    initial begin
        vec_t tbl [10];
        logic [15:0] etype, port;
        logic [7:0]  proto;
        int          trunc;
        bit          acc;

        tbl[0] = '{16'h0800, 8'h11, 16'h3003, 16'h0102, 32'hDEADBEEF, 3, 8'h0F, 0, 1'b1, 0};
        tbl[1] = '{16'h86DD, 8'h11, 16'h3000, 16'h0000, 32'h0,        4, 8'hFF, 0, 1'b0, 0};
        tbl[2] = '{16'h0800, 8'h11, 16'h3001, 16'h0003, 32'h1,        3, 8'hFF, 4, 1'b0, 0};
        tbl[3] = '{16'h0800, 8'h11, 16'h3001, 16'h0004, 32'h2,        0, 8'hFF, 6, 1'b0, 0};
        tbl[4] = '{16'h0800, 8'h11, 16'h3005, 16'hBEEF, 32'h12345678, 8, 8'h3F, 0, 1'b1, 1};
        tbl[5] = '{16'h0800, 8'h06, 16'h3002, 16'h0005, 32'h3,        2, 8'hFF, 0, 1'b0, 0};
        tbl[6] = '{16'h0800, 8'h11, 16'h2FFF, 16'h0006, 32'h4,        2, 8'hFF, 0, 1'b0, 0};
        tbl[7] = '{16'h0800, 8'h11, 16'h3010, 16'h0007, 32'h5,        2, 8'hFF, 0, 1'b0, 0};
        tbl[8] = '{16'h0800, 8'h11, 16'h300F, 16'hFFFF, 32'hCAFEF00D, 5, 8'h7F, 0, 1'b1, 2};
        tbl[9] = '{16'h0800, 8'h11, 16'h3000, 16'h0010, 32'h0BADF00D, 1, 8'h01, 0, 1'b1, 0};

        rst = 1'b1;
        s_axis_tdata = 64'd0; s_axis_tkeep = 8'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_axis_tready, 1'b1);
        check("rst_m_valid", m_axis_tvalid, 1'b0);
        check("rst_m_data", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 73'd0);
        check("rst_side", {m_tlp_tag, m_tlp_seq, m_tlp_tstamp}, 52'd0);
        check("rst_cnts", {pkt_cnt, drop_cnt}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef NETTLP_SEQ_CHECK_EN
        check("rst_seq_err", {seq_err, seq_err_cnt}, 33'd0);
        send_frame(16'h0800, 8'h11, 16'h3000, 16'd0, 32'h10, 2, 8'hFF, 0, 0, 1'b1);
        send_frame(16'h0800, 8'h11, 16'h3000, 16'd1, 32'h11, 2, 8'hFF, 0, 0, 1'b1);
        send_frame(16'h0800, 8'h11, 16'h3000, 16'd5, 32'h12, 2, 8'hFF, 0, 0, 1'b1);
        send_frame(16'h0800, 8'h11, 16'h3000, 16'd6, 32'h13, 2, 8'hFF, 0, 0, 1'b1);
        drain_and_check("seqchk");
        check("seq_err_cnt", seq_err_cnt, 32'd1);
        check("seq_err_pulses", seq_pulses, 1);
`endif

        for (int i = 0; i < 10; i++) begin
            rdy_mode = tbl[i].mode;
            send_frame(tbl[i].etype, tbl[i].proto, tbl[i].port, tbl[i].seq, tbl[i].ts,
                       tbl[i].npay, tbl[i].lkeep, tbl[i].trunc, 0, tbl[i].acc);
            drain_and_check($sformatf("vec%0d", i));
            rdy_mode = 0;
        end

        // Reset during the second payload beat, then a clean packet
        send_frame(16'h0800, 8'h11, 16'h3004, 16'h0020, 32'h55AA55AA, 5, 8'hFF, 0, 7, 1'b1);
        check("abort_m_valid", m_axis_tvalid, 1'b0);
        send_frame(16'h0800, 8'h11, 16'h3006, 16'h0021, 32'h66BB66BB, 3, 8'h03, 0, 0, 1'b1);
        drain_and_check("after_rst");
        check("after_rst_pkt1", pkt_cnt, 32'd1);

        // Random back-to-back frames under random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            etype = ($urandom_range(0, 7) == 0) ? 16'h86DD : 16'h0800;
            proto = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11;
            port  = 16'h2FFC + 16'($urandom_range(0, 24));
            trunc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 6)) : 0;
            acc   = model_accept(etype, proto, port, trunc);
            send_frame(etype, proto, port, 16'($urandom), $urandom, int'($urandom_range(1, 8)),
                       8'hFF >> $urandom_range(0, 7), trunc, 0, acc);
        end
        drain_and_check("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "global timeout");
    end

endmodule
